dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port RV32IM data memory between two requesters: port 0 (core load/store path) and port 1 (debug/program-loader port).
- Performs round-robin arbitration, alignment and range checking, and drives the dmem control signals (mem_read, mem_write, funct3, addr, write_data).
- Registers load data and returns it with a one-cycle response handshake.
- Sits between the core/debug logic and dmem.

Parameters:
- XLEN, 32, data/address width
- FUNCT3_W, 3, width of the load/store funct3 field
- DMEM_W, 1024, dmem depth in words; word index addr[31:2] >= DMEM_W is out of range
- NREQ, 2, number of requesters; fixed at 2 in this revision

Ports:
- clk  in  1  system clock, single clock domain
- n_reset  in  1  asynchronous active-low reset
- req_i[r]  in  1  request from requester r (r = 0, 1)
- we_i[r]  in  1  1 = store, 0 = load
- funct3_i[r]  in  FUNCT3_W  LB/LH/LW/LBU/LHU or SB/SH/SW encoding
- addr_i[r]  in  XLEN  byte address
- wdata_i[r]  in  XLEN  store data
- gnt_o[r]  out  1  request accepted this cycle
- rvalid_o[r]  out  1  response valid (loads and stores)
- err_o[r]  out  1  with rvalid: misaligned or out-of-range access, no memory effect
- rdata_o  out  XLEN  load data, shared bus; qualified by rvalid_o[r]
- mem_read  out  1  to dmem
- mem_write  out  1  to dmem
- mem_funct3  out  FUNCT3_W  to dmem funct3
- mem_addr  out  XLEN  to dmem addr
- mem_wdata  out  XLEN  to dmem write_data
- mem_rdata  in  XLEN  from dmem read_data (combinational)

Behaviour:
- Reset (n_reset low, asynchronous): state = IDLE, last_gnt = 1 (port 0 wins first tie), and all of the following cleared to 0: gnt_o, rvalid_o, err_o, rdata_o, mem_read, mem_write, mem_funct3, mem_addr, mem_wdata.
- Requester protocol: hold req, we, funct3, addr and wdata stable from assertion until the gnt cycle. Deasserting req before gnt is legal and withdraws the request.
- IDLE:
  - Only one req: grant it.
  - Both req: grant the port not equal to last_gnt.
  - gnt_o[w] is combinational in the same cycle; last_gnt <= w; go to RESP.
  - No req: stay in IDLE; mem_read = mem_write = 0.
- Issue (gnt cycle): if the access is legal, drive mem_* from the winner's inputs; mem_read = !we, mem_write = we. dmem commits stores at this clock edge. rdata_o <= mem_rdata at the same edge.
- Illegal access:
  - Halfword with addr[0] = 1, word with addr[1:0] != 0, addr[31:2] >= DMEM_W, or an undefined funct3 for the op.
  - mem_read = mem_write = 0. Grant still given. err_o set in RESP; rdata_o <= 0.
- RESP (exactly one cycle): rvalid_o[w] = 1 and err_o[w] valid; no grant issued this cycle; return to IDLE. Latency is gnt at N, rvalid at N+1. Maximum throughput is one access every 2 cycles.
- Fairness: alternates grants under continuous contention (0,1,0,1,...). A requester waits at most 2 accesses.
- rdata_o holds its value until the next load response.
- A store response carries no data update; rdata_o keeps its previous value.
- Reset mid-operation (in RESP): rvalid is dropped. Any store issued on the gnt edge before reset asserts has already committed.
- Addresses are unsigned; no wrap handling beyond the range check.

Decomposition:
- Shared package rv_pkg holds:
  - state enum: IDLE, RESP
  - funct3 constants (LB/LH/LW/LBU/LHU/SB/SH/SW) from the existing constants header
  - ZERO constant
  - access request struct {we, funct3, addr, wdata}
- One natural sub-module: rr_arbiter2. Combinational 2-way round-robin grant from req[1:0] and last_gnt.

Test Plan:
- Port 0 only: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> gnt in the same cycle; second rvalid_o[0] one cycle after its gnt with rdata_o = 0xDEADBEEF, err = 0.
- Both ports request continuously, 6 accesses -> grant order 0,1,0,1,0,1; no gnt in any RESP cycle.
- Misaligned access: port 1 LW 0x06 and LH 0x03 -> mem_read stays 0, rvalid_o[1] = 1 with err_o[1] = 1, rdata_o = 0.
- Range check: port 0 SW at byte 0x1000 (word 1024, DMEM_W = 1024) -> err = 1, mem_write never asserted; a following LW 0xFFC returns the prior contents.
- Byte store/load: SB 0x21 data 0x80 then LB 0x21 -> 0xFFFFFF80; LBU 0x21 -> 0x00000080.
- Reset asserted asynchronously during RESP -> all outputs 0 immediately; after release, port 0 wins the first contested grant.

Source files
------------

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared types and constants for the dmem arbiter slice
package rv_pkg;

    localparam int XLEN_P     = 32;
    localparam int FUNCT3_W_P = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    localparam logic [FUNCT3_W_P-1:0] F3_LB  = 3'b000;
    localparam logic [FUNCT3_W_P-1:0] F3_LH  = 3'b001;
    localparam logic [FUNCT3_W_P-1:0] F3_LW  = 3'b010;
    localparam logic [FUNCT3_W_P-1:0] F3_LBU = 3'b100;
    localparam logic [FUNCT3_W_P-1:0] F3_LHU = 3'b101;
    localparam logic [FUNCT3_W_P-1:0] F3_SB  = 3'b000;
    localparam logic [FUNCT3_W_P-1:0] F3_SH  = 3'b001;
    localparam logic [FUNCT3_W_P-1:0] F3_SW  = 3'b010;

    localparam logic [XLEN_P-1:0] ZERO = '0;

    typedef struct packed {
        logic                  we;
        logic [FUNCT3_W_P-1:0] funct3;
        logic [XLEN_P-1:0]     addr;
        logic [XLEN_P-1:0]     wdata;
    } acc_req_t;

    // Alignment, funct3 decode and word-range check in one place.
    function automatic logic access_legal(input acc_req_t r, input int unsigned dmem_w);
        logic ok;
        ok = 1'b0;
        if (r.we) begin
            case (r.funct3)
                F3_SB:   ok = 1'b1;
                F3_SH:   ok = !r.addr[0];
                F3_SW:   ok = (r.addr[1:0] == 2'b00);
                default: ok = 1'b0;
            endcase
        end else begin
            case (r.funct3)
                F3_LB, F3_LBU: ok = 1'b1;
                F3_LH, F3_LHU: ok = !r.addr[0];
                F3_LW:         ok = (r.addr[1:0] == 2'b00);
                default:       ok = 1'b0;
            endcase
        end
        return ok && ({2'b00, r.addr[XLEN_P-1:2]} < dmem_w);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way round-robin grant
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt,
    output logic       win
);

    // On a tie the port that did not win last time goes next.
    always_comb begin
        win = 1'b0;
        case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = !last_gnt;
            default: win = 1'b0;
        endcase
        gnt = (req == 2'b00) ? 2'b00 : (win ? 2'b10 : 2'b01);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter in front of single-port dmem
module dmem_arbiter
    import rv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int FUNCT3_W = 3,
    parameter int DMEM_W   = 1024,
    parameter int NREQ     = 2
) (
    input  logic                               clk,
    input  logic                               n_reset,
    input  logic [NREQ-1:0]                    req_i,
    input  logic [NREQ-1:0]                    we_i,
    input  logic [NREQ-1:0][FUNCT3_W-1:0]      funct3_i,
    input  logic [NREQ-1:0][XLEN-1:0]          addr_i,
    input  logic [NREQ-1:0][XLEN-1:0]          wdata_i,
    output logic [NREQ-1:0]                    gnt_o,
    output logic [NREQ-1:0]                    rvalid_o,
    output logic [NREQ-1:0]                    err_o,
    output logic [XLEN-1:0]                    rdata_o,
    output logic                               mem_read,
    output logic                               mem_write,
    output logic [FUNCT3_W-1:0]                mem_funct3,
    output logic [XLEN-1:0]                    mem_addr,
    output logic [XLEN-1:0]                    mem_wdata,
    input  logic [XLEN-1:0]                    mem_rdata
);

    state_e     state;
    logic       last_gnt;
    logic [1:0] arb_gnt;
    logic       win;
    logic       issue;
    logic       legal;
    acc_req_t   sel;

    rr_arbiter2 u_rr (
        .req      (req_i),
        .last_gnt (last_gnt),
        .gnt      (arb_gnt),
        .win      (win)
    );

    assign sel.we     = we_i[win];
    assign sel.funct3 = funct3_i[win];
    assign sel.addr   = addr_i[win];
    assign sel.wdata  = wdata_i[win];

    // Grant and dmem strobes are combinational; gating with n_reset keeps
    // them low while reset is held even if requesters keep req asserted.
    assign issue = n_reset && (state == IDLE) && (req_i != '0);
    assign legal = access_legal(sel, DMEM_W);

    assign gnt_o      = issue ? arb_gnt : '0;
    assign mem_read   = issue && legal && !sel.we;
    assign mem_write  = issue && legal && sel.we;
    assign mem_funct3 = (issue && legal) ? sel.funct3 : '0;
    assign mem_addr   = (issue && legal) ? sel.addr   : ZERO;
    assign mem_wdata  = (issue && legal) ? sel.wdata  : ZERO;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            rvalid_o <= '0;
            err_o    <= '0;
            rdata_o  <= ZERO;
        end else begin
            case (state)
                IDLE: begin
                    rvalid_o <= '0;
                    err_o    <= '0;
                    if (issue) begin
                        state    <= RESP;
                        last_gnt <= win;
                        rvalid_o <= arb_gnt;
                        err_o    <= legal ? '0 : arb_gnt;
                        if (!legal)
                            rdata_o <= ZERO;
                        else if (!sel.we)
                            rdata_o <= mem_rdata;
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    rvalid_o <= '0;
                    err_o    <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic             clk = 1'b0;
    logic             n_reset = 1'b0;
    logic [1:0]       req_i = '0;
    logic [1:0]       we_i = '0;
    logic [1:0][2:0]  funct3_i = '0;
    logic [1:0][31:0] addr_i = '0;
    logic [1:0][31:0] wdata_i = '0;
    logic [1:0]       gnt_o, rvalid_o, err_o;
    logic [31:0]      rdata_o;
    logic             mem_read, mem_write;
    logic [2:0]       mem_funct3;
    logic [31:0]      mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .req_i      (req_i),
        .we_i       (we_i),
        .funct3_i   (funct3_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .gnt_o      (gnt_o),
        .rvalid_o   (rvalid_o),
        .err_o      (err_o),
        .rdata_o    (rdata_o),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_funct3 (mem_funct3),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Behavioural dmem: combinational read, write on clock edge.
    always_comb begin
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        w = mem[mem_addr[11:2]];
        b = 8'(w >> (8 * mem_addr[1:0]));
        h = 16'(w >> (16 * mem_addr[1]));
        mem_rdata = 32'h0;
        case (mem_funct3)
            3'b000:  mem_rdata = {{24{b[7]}}, b};
            3'b001:  mem_rdata = {{16{h[15]}}, h};
            3'b010:  mem_rdata = w;
            3'b100:  mem_rdata = {24'h0, b};
            3'b101:  mem_rdata = {16'h0, h};
            default: mem_rdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_write) begin
            case (mem_funct3)
                3'b000:  mem[mem_addr[11:2]][8*mem_addr[1:0] +: 8] <= mem_wdata[7:0];
                3'b001:  mem[mem_addr[11:2]][16*mem_addr[1] +: 16] <= mem_wdata[15:0];
                default: mem[mem_addr[11:2]] <= mem_wdata;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        req_i   = '0;
        n_reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 n_reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Single access from one port; called one time unit after a rising edge.
    task automatic access(input int p, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic exp_err, input logic [31:0] exp_rd);
        int n;
        req_i[p]    = 1'b1;
        we_i[p]     = we;
        funct3_i[p] = f3;
        addr_i[p]   = a;
        wdata_i[p]  = wd;
        #1;
        n = 0;
        while (!gnt_o[p] && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("gnt", 32'(gnt_o[p]), 32'd1);
        check("mem_read", 32'(mem_read), 32'(!exp_err && !we));
        check("mem_write", 32'(mem_write), 32'(!exp_err && we));
        @(posedge clk);
        #1;
        req_i[p] = 1'b0;
        check("rvalid", 32'(rvalid_o), 32'(2'b01 << p));
        check("err", 32'(err_o), exp_err ? 32'(2'b01 << p) : 32'd0);
        check("rdata", rdata_o, exp_rd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        #12;
        check("rst_gnt", 32'(gnt_o), 32'd0);
        check("rst_rvalid", 32'(rvalid_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        do_reset();

        access(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        access(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
        access(1, 1'b0, 3'b010, 32'h06, 32'h0, 1'b1, 32'h0);
        access(1, 1'b0, 3'b001, 32'h03, 32'h0, 1'b1, 32'h0);
        access(0, 1'b1, 3'b010, 32'hFFC, 32'h12345678, 1'b0, 32'h0);
        access(0, 1'b1, 3'b010, 32'h1000, 32'hCAFEF00D, 1'b1, 32'h0);
        access(0, 1'b0, 3'b010, 32'hFFC, 32'h0, 1'b0, 32'h12345678);
        access(0, 1'b1, 3'b000, 32'h21, 32'h80, 1'b0, 32'h12345678);
        access(0, 1'b0, 3'b000, 32'h21, 32'h0, 1'b0, 32'hFFFFFF80);
        access(0, 1'b0, 3'b100, 32'h21, 32'h0, 1'b0, 32'h00000080);
        access(1, 1'b0, 3'b111, 32'h20, 32'h0, 1'b1, 32'h0);

        // Continuous contention after reset: grants alternate starting at port 0.
        do_reset();
        we_i = 2'b00;
        funct3_i[0] = 3'b010; funct3_i[1] = 3'b010;
        addr_i[0] = 32'h10;   addr_i[1] = 32'h10;
        req_i = 2'b11;
        #1;
        for (int k = 0; k < 6; k++) begin
            logic [1:0] exp_g;
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            check("cont_gnt", 32'(gnt_o), 32'(exp_g));
            @(posedge clk);
            #1;
            check("cont_resp_gnt", 32'(gnt_o), 32'd0);
            check("cont_rvalid", 32'(rvalid_o), 32'(exp_g));
            check("cont_rdata", rdata_o, 32'hDEADBEEF);
            @(posedge clk);
            #1;
        end
        req_i = 2'b00;
        @(posedge clk);
        #1;

        // Asynchronous reset while a response is in flight.
        req_i[0] = 1'b1; we_i[0] = 1'b0; funct3_i[0] = 3'b010; addr_i[0] = 32'h10;
        #1;
        @(posedge clk);
        #1;
        check("pre_rst_rvalid", 32'(rvalid_o), 32'd1);
        #2 n_reset = 1'b0;
        #1;
        check("async_rvalid", 32'(rvalid_o), 32'd0);
        check("async_rdata", rdata_o, 32'd0);
        check("async_gnt", 32'(gnt_o), 32'd0);
        check("async_mem_read", 32'(mem_read), 32'd0);
        req_i = 2'b11;
        @(posedge clk);
        #1 n_reset = 1'b1;
        #1;
        check("post_rst_gnt", 32'(gnt_o), 32'd1);
        @(posedge clk);
        #1;
        req_i = 2'b00;
        check("post_rst_rdata", rdata_o, 32'hDEADBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
